// File: rtl/axis_packet_arbiter.sv
// Round-robin packet arbiter: four AXI4-Stream sources share one master link.
// A source keeps the link for a whole packet. After its tlast beat the winner
// drops to the lowest priority for the next arbitration.
module axis_packet_arbiter #(
  parameter int unsigned DATABUSWIDTH = 16,
  parameter int unsigned TDESTWIDTH   = 2,
  parameter int unsigned MAXBEATS     = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     s_axis_tvalid,
  output logic [3:0]                     s_axis_tready,
  input  logic [4*8*DATABUSWIDTH-1:0]    s_axis_tdata,
  input  logic [4*DATABUSWIDTH-1:0]      s_axis_tkeep,
  input  logic [3:0]                     s_axis_tlast,
  input  logic [4*TDESTWIDTH-1:0]        s_axis_tdest,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [8*DATABUSWIDTH-1:0]      m_axis_tdata,
  output logic [DATABUSWIDTH-1:0]        m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic [TDESTWIDTH-1:0]          m_axis_tdest,
  output logic [3:0]                     grant,
  output logic                           busy,
  output logic                           overrun_err
);

  localparam int unsigned DW = 8 * DATABUSWIDTH;
  localparam int unsigned KW = DATABUSWIDTH;
  localparam int unsigned TW = TDESTWIDTH;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  prio_ptr_q, prio_ptr_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic        overrun_err_q, overrun_err_d;

  logic        in_xfer;
  logic [1:0]  gidx;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;
  logic        pick_valid;
  logic        beat_fire;

  assign in_xfer = (state_q == XFER);

  // Encode the registered one-hot grant into a mux select.
  always_comb begin
    gidx = 2'd0;
    case (grant_q)
      4'b0010: gidx = 2'd1;
      4'b0100: gidx = 2'd2;
      4'b1000: gidx = 2'd3;
      default: gidx = 2'd0;
    endcase
  end

  // Find the first requester searching upward from prio_ptr, wrapping at 4.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = prio_ptr_q;
    cand       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = prio_ptr_q + 2'(k);
      if (!pick_valid && s_axis_tvalid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Datapath mux from the granted source; tready only from registered grant.
  always_comb begin
    m_axis_tvalid = in_xfer & s_axis_tvalid[gidx];
    m_axis_tdata  = s_axis_tdata[int'(gidx)*DW +: DW];
    m_axis_tkeep  = s_axis_tkeep[int'(gidx)*KW +: KW];
    m_axis_tlast  = s_axis_tlast[gidx];
    m_axis_tdest  = s_axis_tdest[int'(gidx)*TW +: TW];
    s_axis_tready = in_xfer ? (grant_q & {4{m_axis_tready}}) : 4'b0000;
  end

  assign beat_fire = m_axis_tvalid & m_axis_tready;

  // Next-state: arbitrate in IDLE, hold the grant until the tlast beat in XFER.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    prio_ptr_d    = prio_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    overrun_err_d = overrun_err_q;
    if (!in_xfer) begin
      beat_cnt_d = 16'd0;
      if (pick_valid) begin
        state_d = XFER;
        grant_d = 4'b0001 << pick_idx;
      end
    end else if (beat_fire) begin
      if (beat_cnt_q != 16'hFFFF) begin
        beat_cnt_d = beat_cnt_q + 16'd1;
      end
      // Flag only; the packet still passes through untruncated.
      if (!m_axis_tlast && (({1'b0, beat_cnt_q} + 17'd1) == 17'(MAXBEATS))) begin
        overrun_err_d = 1'b1;
      end
      if (m_axis_tlast) begin
        state_d    = IDLE;
        grant_d    = 4'b0000;
        prio_ptr_d = gidx + 2'd1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= 4'b0000;
      prio_ptr_q    <= 2'd0;
      beat_cnt_q    <= 16'd0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      prio_ptr_q    <= prio_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = in_xfer;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: queued sources feed the DUT,
// a monitor logs every master-side beat, and the main sequence checks it.
module tb_axis_packet_arbiter;

  localparam int unsigned DBW = 2;
  localparam int unsigned TDW = 2;

  logic                 clk;
  logic                 reset;
  logic [3:0]           s_axis_tvalid;
  logic [3:0]           s_axis_tready;
  logic [4*8*DBW-1:0]   s_axis_tdata;
  logic [4*DBW-1:0]     s_axis_tkeep;
  logic [3:0]           s_axis_tlast;
  logic [4*TDW-1:0]     s_axis_tdest;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [8*DBW-1:0]     m_axis_tdata;
  logic [DBW-1:0]       m_axis_tkeep;
  logic                 m_axis_tlast;
  logic [TDW-1:0]       m_axis_tdest;
  logic [3:0]           grant;
  logic                 busy;
  logic                 overrun_err;

  axis_packet_arbiter #(
    .DATABUSWIDTH(DBW),
    .TDESTWIDTH  (TDW),
    .MAXBEATS    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tdest (s_axis_tdest),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tdest (m_axis_tdest),
    .grant        (grant),
    .busy         (busy),
    .overrun_err  (overrun_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Source queues: entry = {tdest, tlast, tdata}.
  logic [18:0] mem [4][64];
  int          wr [4];
  int          rd [4];
  logic [3:0]  en;
  logic        flush;

  // Monitor log of transferred master beats.
  logic [15:0] mon_data  [128];
  logic        mon_last  [128];
  logic [1:0]  mon_dest  [128];
  logic [3:0]  mon_grant [128];
  int          mon_cyc   [128];
  int          mon_n;
  int          cyc;

  int n_tests;
  int n_fail;
  int base;

  // Present the head of each enabled, non-empty queue.
  always_comb begin
    s_axis_tvalid = 4'b0000;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 4'b0000;
    s_axis_tdest  = '0;
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid[i]         = en[i] && (rd[i] != wr[i]);
      s_axis_tdata[i*16 +: 16] = mem[i][rd[i][5:0]][15:0];
      s_axis_tlast[i]          = mem[i][rd[i][5:0]][16];
      s_axis_tdest[i*2 +: 2]   = mem[i][rd[i][5:0]][18:17];
      s_axis_tkeep[i*2 +: 2]   = 2'(i + 1);
    end
  end

  // Pop a queue entry on each accepted source beat.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (flush) rd[i] <= wr[i];
      else if (s_axis_tvalid[i] && s_axis_tready[i]) rd[i] <= rd[i] + 1;
    end
  end

  // Log master-side beats with their cycle number and the grant at transfer.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      mon_data[mon_n]  <= m_axis_tdata;
      mon_last[mon_n]  <= m_axis_tlast;
      mon_dest[mon_n]  <= m_axis_tdest;
      mon_grant[mon_n] <= grant;
      mon_cyc[mon_n]   <= cyc;
      mon_n            <= mon_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int s, input logic [15:0] d, input logic l, input logic [1:0] dst);
    mem[s][wr[s]] = {dst, l, d};
    wr[s]++;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k;
    k = 0;
    while (mon_n < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("beat_count", mon_n, target);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b1;
    en = 4'b0000;
    m_axis_tready = 1'b0;
    for (int s = 0; s < 4; s++) wr[s] = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant", grant, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_s_tready", s_axis_tready, 4'b0000);
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_overrun", overrun_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;

    // Single source 2, three beats.
    push(2, 16'h00A0, 1'b0, 2'b01);
    push(2, 16'h00A1, 1'b0, 2'b01);
    push(2, 16'h00A2, 1'b1, 2'b01);
    base = mon_n;
    @(negedge clk);
    en = 4'b0100;
    m_axis_tready = 1'b1;
    #1;
    check("a_idle_grant", grant, 4'b0000);
    check("a_idle_mvalid", m_axis_tvalid, 1'b0);
    check("a_idle_tready", s_axis_tready, 4'b0000);
    @(negedge clk);
    #1;
    check("a_grant", grant, 4'b0100);
    check("a_busy", busy, 1'b1);
    check("a_tready", s_axis_tready, 4'b0100);
    check("a_mvalid", m_axis_tvalid, 1'b1);
    check("a_tdata0", m_axis_tdata, 16'h00A0);
    check("a_tkeep", m_axis_tkeep, 2'b11);
    wait_beats(base + 3, 10);
    check("a_grant_after", grant, 4'b0000);
    check("a_busy_after", busy, 1'b0);
    for (int b = 0; b < 3; b++) begin
      check("a_data", mon_data[base+b], 32'h00A0 + 32'(b));
      check("a_dest", mon_dest[base+b], 2'b01);
      check("a_last", mon_last[base+b], (b == 2) ? 1'b1 : 1'b0);
    end
    check("a_contig1", mon_cyc[base+1] - mon_cyc[base], 1);
    check("a_contig2", mon_cyc[base+2] - mon_cyc[base+1], 1);
    en = 4'b0000;

    // Fairness from reset: sources 0,1 hold two packets, 2,3 hold one.
    pulse_reset();
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < ((s < 2) ? 2 : 1); k++) begin
        push(s, 16'((s << 8) | (k << 4) | 0), 1'b0, 2'(s));
        push(s, 16'((s << 8) | (k << 4) | 1), 1'b1, 2'(s));
      end
    end
    base = mon_n;
    en = 4'b1111;
    wait_beats(base + 12, 60);
    for (int p = 0; p < 6; p++) begin
      check("b_grant", mon_grant[base+2*p], 32'(4'b0001 << (p % 4)));
      check("b_data0", mon_data[base+2*p], 32'(((p % 4) << 8) | ((p / 4) << 4)));
      check("b_data1", mon_data[base+2*p+1], 32'(((p % 4) << 8) | ((p / 4) << 4) | 1));
      check("b_last", {mon_last[base+2*p], mon_last[base+2*p+1]}, 2'b01);
      check("b_contig", mon_cyc[base+2*p+1] - mon_cyc[base+2*p], 1);
      if (p < 5) check("b_gap", mon_cyc[base+2*p+2] - mon_cyc[base+2*p+1], 2);
    end
    en = 4'b0000;

    // Backpressure on a 4-beat packet from source 1; others wait behind it.
    for (int b = 0; b < 4; b++) push(1, 16'(16'h00C0 + b), (b == 3), 2'b11);
    push(0, 16'h0030, 1'b1, 2'b00);
    push(2, 16'h0032, 1'b1, 2'b10);
    push(3, 16'h0033, 1'b1, 2'b11);
    base = mon_n;
    @(negedge clk);
    en = 4'b0010;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      m_axis_tready = (i % 2 == 0);
      if (i == 0) en = 4'b1111;
      #1;
      check("c_tready", s_axis_tready, (i % 2 == 0) ? 4'b0010 : 4'b0000);
      check("c_grant", grant, 4'b0010);
    end
    m_axis_tready = 1'b1;
    wait_beats(base + 7, 30);
    for (int b = 0; b < 4; b++) begin
      check("c_data", mon_data[base+b], 32'h00C0 + 32'(b));
      check("c_last", mon_last[base+b], (b == 3) ? 1'b1 : 1'b0);
    end
    check("c_next_g2", mon_grant[base+4], 4'b0100);
    check("c_next_g3", mon_grant[base+5], 4'b1000);
    check("c_next_g0", mon_grant[base+6], 4'b0001);
    check("c_next_d0", mon_data[base+6], 16'h0030);
    en = 4'b0000;

    // Packet lock: source 3 mid-packet while sources 0 and 1 request.
    for (int b = 0; b < 4; b++) push(3, 16'(16'h00D0 + b), (b == 3), 2'b00);
    push(0, 16'h00E0, 1'b1, 2'b01);
    push(1, 16'h00F0, 1'b1, 2'b10);
    base = mon_n;
    @(negedge clk);
    en = 4'b1000;
    @(negedge clk);
    #1;
    check("d_grant", grant, 4'b1000);
    @(negedge clk);
    en = 4'b1011;
    #1;
    check("d_lock1", grant, 4'b1000);
    @(negedge clk);
    en = 4'b0011;
    #1;
    check("d_drop_mvalid", m_axis_tvalid, 1'b0);
    check("d_drop_grant", grant, 4'b1000);
    check("d_drop_busy", busy, 1'b1);
    @(negedge clk);
    en = 4'b1011;
    #1;
    check("d_resume_mvalid", m_axis_tvalid, 1'b1);
    check("d_lock2", grant, 4'b1000);
    wait_beats(base + 6, 30);
    for (int b = 0; b < 4; b++) begin
      check("d_data", mon_data[base+b], 32'h00D0 + 32'(b));
      check("d_beat_grant", mon_grant[base+b], 4'b1000);
    end
    check("d_next_g0", mon_grant[base+4], 4'b0001);
    check("d_next_d0", mon_data[base+4], 16'h00E0);
    check("d_next_g1", mon_grant[base+5], 4'b0010);
    check("d_no_overrun", overrun_err, 1'b0);
    en = 4'b0000;

    // Overrun with MAXBEATS=4: six-beat packet from source 0.
    for (int b = 0; b < 6; b++) push(0, 16'(16'h0090 + b), (b == 5), 2'b10);
    base = mon_n;
    @(negedge clk);
    en = 4'b0001;
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      #1;
      check("e_overrun_step", overrun_err, (b >= 4) ? 1'b1 : 1'b0);
    end
    wait_beats(base + 6, 20);
    check("e_overrun_sticky", overrun_err, 1'b1);
    for (int b = 0; b < 6; b++) begin
      check("e_data", mon_data[base+b], 32'h0090 + 32'(b));
      check("e_last", mon_last[base+b], (b == 5) ? 1'b1 : 1'b0);
    end
    en = 4'b0000;

    // Reset during beat 2 of a 5-beat packet from source 2.
    for (int b = 0; b < 5; b++) push(2, 16'(16'h0070 + b), (b == 4), 2'b01);
    @(negedge clk);
    en = 4'b0100;
    @(negedge clk);
    #1;
    check("f_grant", grant, 4'b0100);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("f_rst_tready", s_axis_tready, 4'b0000);
    check("f_rst_mvalid", m_axis_tvalid, 1'b0);
    check("f_rst_grant", grant, 4'b0000);
    check("f_rst_busy", busy, 1'b0);
    check("f_rst_overrun", overrun_err, 1'b0);
    en = 4'b0000;
    flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    push(0, 16'h0050, 1'b1, 2'b00);
    push(1, 16'h0051, 1'b1, 2'b01);
    base = mon_n;
    en = 4'b0011;
    wait_beats(base + 2, 20);
    check("f_after_g0", mon_grant[base], 4'b0001);
    check("f_after_d0", mon_data[base], 16'h0050);
    check("f_after_g1", mon_grant[base+1], 4'b0010);
    en = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Round-robin packet arbiter sharing one AXI4-Stream master link among four AXI4-Stream sources. It sits upstream of the tdest-addressed stream slaves that feed the per-destination FIFOs, and grants the link to exactly one source for a whole packet, ending at the tlast beat. Fairness comes from a rotating priority pointer. Beat counting provides an overrun status flag.

## Interface
- DATABUSWIDTH, 16, data bus width in bytes.
- TDESTWIDTH, 2, tdest width in bits.
- MAXBEATS, 256, maximum legal beats per packet. Range 2..65535.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- s_axis_tvalid  in  4  per-source tvalid. Bit i is source i.
- s_axis_tready  out  4  per-source tready.
- s_axis_tdata  in  4*8*DATABUSWIDTH  concatenated tdata. Source i occupies slice i.
- s_axis_tkeep  in  4*DATABUSWIDTH  concatenated tkeep.
- s_axis_tlast  in  4  per-source tlast.
- s_axis_tdest  in  4*TDESTWIDTH  concatenated tdest.
- m_axis_tvalid  out  1  merged tvalid.
- m_axis_tready  in  1  downstream tready.
- m_axis_tdata  out  8*DATABUSWIDTH  merged tdata.
- m_axis_tkeep  out  DATABUSWIDTH  merged tkeep.
- m_axis_tlast  out  1  merged tlast.
- m_axis_tdest  out  TDESTWIDTH  merged tdest.
- grant  out  4  one-hot current grant. 0 when idle.
- busy  out  1  high while a packet is in progress.
- overrun_err  out  1  sticky: a packet exceeded MAXBEATS beats.

## Operation
- The state machine has two states, IDLE and XFER. Registers are state, grant (one-hot), prio_ptr (2 bits), beat_cnt (16 bits) and overrun_err.
- In IDLE:
  - All s_axis_tready are 0 and m_axis_tvalid is 0.
  - If any s_axis_tvalid is high, select the first requester found searching upward from prio_ptr, modulo 4.
  - Register its one-hot grant and go to XFER. Clear beat_cnt.
- In XFER, the datapath is a combinational mux from the granted source:
  - m_axis_tvalid/tdata/tkeep/tlast/tdest equal the granted source's signals.
  - s_axis_tready[g] = m_axis_tready.
  - s_axis_tready of all other sources is 0.
- A beat is transferred when m_axis_tvalid & m_axis_tready. On each transferred beat, beat_cnt increments, saturating at 65535.
- overrun_err is set when a beat transfers with tlast=0 and beat_cnt+1 == MAXBEATS. It stays set until reset. The packet is not truncated.
- When a beat transfers with tlast=1:
  - Go to IDLE and clear grant.
  - Set prio_ptr to g+1 modulo 4, so the last winner has lowest priority next.
- While in XFER, the grant never changes, regardless of other sources' tvalid.
- busy = (state == XFER).
- A source dropping tvalid mid-packet is legal. The grant holds and m_axis_tvalid follows that source.

## Timing
- Reset values:
  - state IDLE, grant 0, prio_ptr 0, beat_cnt 0, overrun_err 0, busy 0.
  - All s_axis_tready 0 and m_axis_tvalid 0.
- Asserting reset mid-packet aborts the packet immediately. The partial packet is not completed, and upstream and downstream must also be reset.
- Arbitration latency:
  - A request seen in IDLE at edge N gives grant, busy and the first possible beat in the cycle after edge N.
  - Minimum one dead cycle between packets (XFER→IDLE→XFER).
  - A single-beat packet occupies one XFER cycle plus one IDLE cycle.
- Throughput within a packet is one beat per cycle while tvalid and tready are both high.
- Simultaneous requests in IDLE are resolved by prio_ptr only.
- A requester that asserts tvalid on the same cycle another packet's tlast transfers is considered at the next IDLE cycle.
- There is no combinational path from any s_axis_tvalid to any s_axis_tready. Tready depends only on registered grant and m_axis_tready.

## Test plan
- Single source: source 2 sends a 3-beat packet with tdata 0xA0,0xA1,0xA2, tdest 2'b01, m_axis_tready held at 1.
  - grant=4'b0100 one cycle after tvalid rises.
  - m_axis carries 3 beats in 3 consecutive cycles with tdest=01, tlast on 0xA2.
  - grant=0 on the following cycle.
- Fairness: all four sources continuously offer 2-beat packets from reset.
  - Grant order is 0,1,2,3,0,1.
  - Each packet is contiguous, with exactly one idle cycle between packets.
- Backpressure: toggle m_axis_tready 1,0,1,0 during a 4-beat packet from source 1.
  - s_axis_tready[1] mirrors m_axis_tready.
  - All beats arrive in order with none dropped or duplicated.
  - Other sources' tready stays 0.
- Packet lock: source 3 is mid-packet when source 0 raises tvalid.
  - The grant stays on source 3 until its tlast transfers.
  - Source 0 is granted next (prio_ptr=0).
- Overrun: MAXBEATS=4, source 0 sends 6 beats.
  - overrun_err rises on the 4th beat's transfer edge and stays 1.
  - All 6 beats pass through.
- Reset mid-packet: assert reset during beat 2 of 5.
  - All tready, m_axis_tvalid, grant and busy go to 0 immediately.
  - After release, a new request is granted normally with prio_ptr=0.
